// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants, FSM state encoding and address helpers for the 40x24
// text screen buffer (vga_text_buffer and its text_ram).
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned COLS   = 40;
    localparam int unsigned ROWS   = 24;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 10;

    localparam logic [5:0] SPACE_CODE = 6'h20;
    localparam logic [6:0] CR_CODE    = 7'h0D;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        SCROLL = ST_SCROLL
    } state_e;

    // Logical row -> physical row for the circular screen (inputs both < ROWS).
    function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= 6'(ROWS)) begin
            sum = sum - 6'(ROWS);
        end
        return sum[4:0];
    endfunction

    // prow*40 + col, written as shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [5:0] col);
        return ({5'b0, prow} << 5) + ({5'b0, prow} << 3) + {4'b0, col};
    endfunction

endpackage

// File: rtl/text_ram.sv
// ---------------------------------------------------------------------------
// text_ram
// Simple dual-port screen RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
// Ports:
//   clk25    - clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address (sampled every cycle)
//   rd_data  - registered read data, one cycle after rd_addr
// ---------------------------------------------------------------------------
module text_ram
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = CELLS,
    parameter int unsigned AW    = ADDR_W,
    parameter int unsigned DW    = 6
) (
    input  logic          clk25,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk25) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_text_buffer.sv
// ---------------------------------------------------------------------------
// vga_text_buffer
// Apple-1 style 40x24 terminal screen memory feeding the font ROM.
// Write side takes ASCII over valid/ready and handles printable characters,
// CR, line wrap, hardware scroll (circular top_row) and clear-screen.
// Read side returns the 6-bit glyph for (rd_col,rd_row) one cycle later,
// with the cursor glyph substituted and blanking-area reads forced to space.
//
// Build option: define VGA_CURSOR_BLINK_EN to blink the cursor every
// BLINK_FRAMES frame_tick pulses; otherwise the cursor is always shown and
// frame_tick is ignored.
//
// Ports:
//   clk25      - pixel clock, sole clock
//   rst        - synchronous active-high reset
//   wr_valid   - wr_data offered
//   wr_data    - ASCII byte
//   wr_ready   - high only when idle; byte taken on wr_valid&&wr_ready
//   clr        - one-cycle pulse: clear screen and home cursor
//   frame_tick - one pulse per video frame
//   rd_col     - display column being fetched
//   rd_row     - display row being fetched (0 = top)
//   rd_char    - glyph for previous cycle's (rd_col,rd_row)
//   cur_col    - cursor column
//   cur_row    - cursor row
//
// state  | meaning
// IDLE   | accepting bytes, cursor visible
// CLEAR  | writing space to every cell, cell index in cnt_q
// SCROLL | writing space to the new bottom row, column in cnt_q
// ---------------------------------------------------------------------------
module vga_text_buffer
    import vga_pkg::*;
#(
    parameter logic [5:0]  CURSOR_CHAR  = 6'h00,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [6:0] wr_data,
    output logic       wr_ready,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic [5:0] rd_col,
    input  logic [4:0] rd_row,
    output logic [5:0] rd_char,
    output logic [5:0] cur_col,
    output logic [4:0] cur_row
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [5:0]          cur_col_q, cur_col_d;
    logic [4:0]          cur_row_q, cur_row_d;
    logic [4:0]          top_row_q, top_row_d;
    logic                blank_q;
    logic                cursor_q;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_wa;
    logic [5:0]          ram_wd;
    logic [ADDR_W-1:0]   ram_ra;
    logic [5:0]          ram_rd;

    logic [4:0]          cur_phys;
    logic [4:0]          top_inc;
    logic                newline;
    logic                rd_in_range;
    logic                cursor_hit;
    logic                blink_on;

    assign cur_phys = phys_row(cur_row_q, top_row_q);
    assign top_inc  = (top_row_q == 5'(ROWS - 1)) ? 5'd0 : top_row_q + 5'd1;
    assign wr_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        top_row_d = top_row_q;
        ram_we    = 1'b0;
        ram_wa    = cell_addr(cur_phys, cur_col_q);
        ram_wd    = SPACE_CODE;
        newline   = 1'b0;

        if (clr) begin
            // clr overrides everything, including a byte offered this cycle.
            state_d   = CLEAR;
            cnt_d     = '0;
            cur_col_d = '0;
            cur_row_d = '0;
            top_row_d = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    ram_we = 1'b1;
                    ram_wa = cnt_q;
                    if (cnt_q == ADDR_W'(CELLS - 1)) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        cur_col_d = '0;
                        cur_row_d = '0;
                        top_row_d = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                SCROLL: begin
                    // cur_row is ROWS-1 here, so cur_phys is the recycled row.
                    ram_we = 1'b1;
                    ram_wa = cell_addr(cur_phys, cnt_q[5:0]);
                    if (cnt_q == ADDR_W'(COLS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (wr_valid) begin
                        if (wr_data >= 7'h20) begin
                            ram_we = 1'b1;
                            ram_wd = wr_data[5:0];
                            if (cur_col_q == 6'(COLS - 1)) begin
                                newline = 1'b1;
                            end else begin
                                cur_col_d = cur_col_q + 6'd1;
                            end
                        end else if (wr_data == CR_CODE) begin
                            newline = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            endcase

            if (newline) begin
                cur_col_d = '0;
                if (cur_row_q < 5'(ROWS - 1)) begin
                    cur_row_d = cur_row_q + 5'd1;
                end else begin
                    top_row_d = top_inc;
                    state_d   = SCROLL;
                    cnt_d     = '0;
                end
            end
        end
    end

    assign rd_in_range = (rd_col < 6'(COLS)) && (rd_row < 5'(ROWS));
    assign ram_ra      = rd_in_range ? cell_addr(phys_row(rd_row, top_row_q), rd_col) : '0;
    assign cursor_hit  = (state_q == IDLE) && blink_on &&
                         (rd_col == cur_col_q) && (rd_row == cur_row_q);

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            cur_col_q <= '0;
            cur_row_q <= '0;
            top_row_q <= '0;
            blank_q   <= 1'b1;
            cursor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            top_row_q <= top_row_d;
            blank_q   <= ~rd_in_range;
            cursor_q  <= cursor_hit;
        end
    end

`ifdef VGA_CURSOR_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Down-counter reloads to BLINK_FRAMES-1, so the phase flips on every
    // BLINK_FRAMES-th frame_tick.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_tick) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d = BW'(BLINK_FRAMES - 1);
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            blink_cnt_q <= BW'(BLINK_FRAMES - 1);
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_on = blink_on_q;
`else
    logic unused_blink;

    // Blink disabled: frame_tick and BLINK_FRAMES have no effect.
    assign unused_blink = frame_tick & (BLINK_FRAMES != 0);
    assign blink_on     = 1'b1;
`endif

    text_ram #(
        .DEPTH (CELLS),
        .AW    (ADDR_W),
        .DW    (6)
    ) u_text_ram (
        .clk25   (clk25),
        .we      (ram_we & ~rst),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .rd_addr (ram_ra),
        .rd_data (ram_rd)
    );

    assign rd_char = blank_q  ? SPACE_CODE  :
                     cursor_q ? CURSOR_CHAR : ram_rd;
    assign cur_col = cur_col_q;
    assign cur_row = cur_row_q;

endmodule
